niosii_system_sysid_checker: RTL and testbench
==============================================

// Module: niosII_system_sysid_checker
// PURPOSE
//  Avalon-MM read master that sits upstream of the system-ID slave and drives its control port.
//  After reset, or on request, it reads the ID word (offset 0x0) and then the timestamp word (offset 0x4).
//  It compares both against build-time expected values and reports pass/fail/timeout.
//  Reset/boot logic uses the result to hold off software on a hardware/software image mismatch.
// PARAMETERS
//  ADDR_W          32          Avalon byte-address width of avm_address
//  BASE_ADDR       0           byte base address of the sysid control slave
//  EXPECTED_ID     0           expected 32-bit word at BASE_ADDR+0
//  EXPECTED_TS     1486769255  expected 32-bit word at BASE_ADDR+4 (0x589E4C67)
//  TIMEOUT_CYCLES  255         max consecutive waitrequest cycles per read, 1..65535
//  AUTO_START      1           1 = run one check automatically after reset release
// PORTS
//  clock            in   1       system clock, all logic rising-edge
//  reset_n          in   1       asynchronous active-low reset
//  start            in   1       1-cycle request to (re)run the check
//  avm_address      out  ADDR_W  Avalon-MM byte address
//  avm_read         out  1       Avalon-MM read strobe
//  avm_waitrequest  in   1       slave stall
//  avm_readdata     in   32      read data, valid when avm_read & !avm_waitrequest
//  busy             out  1       check in progress
//  done             out  1       level; check finished (pass, fail or timeout)
//  id_ok            out  1       captured ID == EXPECTED_ID (valid when done)
//  ts_ok            out  1       captured timestamp == EXPECTED_TS (valid when done)
//  timeout          out  1       a read stalled for TIMEOUT_CYCLES cycles
//  captured_id      out  32      last ID word read
//  captured_ts      out  32      last timestamp word read
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, every output 0, avm_address = 0, timeout counter 0.
//  - States: IDLE -> RD_ID -> RD_TS -> CHECK -> DONE. Timeout from RD_ID or RD_TS goes straight to DONE.
//  - IDLE: on start=1, or on the first clock after reset if AUTO_START=1 (one-shot armed flag):
//    go to RD_ID with avm_read=1, avm_address=BASE_ADDR, busy=1.
//  - RD_ID/RD_TS handshake:
//    - avm_read and avm_address are held stable while avm_waitrequest=1.
//    - On the edge where avm_waitrequest=0, avm_readdata is captured into captured_id (RD_ID) or captured_ts (RD_TS).
//    - RD_ID -> RD_TS with avm_address = BASE_ADDR+4. RD_TS -> CHECK with avm_read=0.
//  - Timeout counter:
//    - Cleared on entry to each read state; increments on each cycle with avm_waitrequest=1.
//    - When it reaches TIMEOUT_CYCLES: avm_read=0, timeout=1, id_ok=ts_ok=0, go to DONE.
//    - A read accepted on the same cycle the count reaches its limit completes normally; no timeout.
//  - CHECK: register id_ok and ts_ok using full 32-bit equality. Go to DONE.
//  - DONE: done=1, busy=0. Flags and captured words hold until the next start.
//  - Latency with zero wait states: start sampled at edge k, then read visible k..k+2, done=1 after edge k+3.
//  - Restart: start in DONE clears done, id_ok, ts_ok and timeout at the next edge and enters RD_ID.
//    captured_* keep old values until overwritten.
//  - start while busy is ignored; no queuing.
//  - reset_n low mid-read: read deasserts immediately (asynchronous). No partial result is kept.
//    AUTO_START re-arms and the check reruns after release.
//  - avm_address[1:0] is always 0; the master never issues a write.
// TESTING
//  1 Zero-wait slave returning 0 / 0x589E4C67, AUTO_START=1
//    -> reads at 0x0 then 0x4; done=1 three edges after start; id_ok=ts_ok=1; timeout=0.
//  2 Slave returns TS 0x589E4C66
//    -> done=1, id_ok=1, ts_ok=0, captured_ts=0x589E4C66.
//  3 waitrequest=1 for 3 cycles on each read
//    -> avm_read/avm_address stable throughout; done after 3+6 edges; pass.
//  4 waitrequest stuck high, TIMEOUT_CYCLES=4
//    -> avm_read drops after 4 stall cycles; timeout=1, done=1, id_ok=ts_ok=0.
//  5 start pulsed while busy, then again in DONE
//    -> first ignored; second clears done next edge and reruns both reads.
//  6 reset_n asserted during RD_TS
//    -> all outputs 0 asynchronously; after release the auto-check repeats and passes.

Source files
------------

// File: rtl/niosii_system_sysid_checker.sv
// ---------------------------------------------------------------------------
// niosii_system_sysid_checker
//
// Avalon-MM read master that checks the system-ID slave. It reads the ID word
// at BASE_ADDR+0 and then the timestamp word at BASE_ADDR+4, and compares both
// against build-time expected values. Boot logic uses the result to hold off
// software when the hardware and software images do not match.
//
// Ports
//   clock            in   system clock, all logic on the rising edge
//   reset_n          in   asynchronous active-low reset
//   start            in   one-cycle request to (re)run the check
//   avm_address      out  Avalon-MM byte address (bits [1:0] always 0)
//   avm_read         out  Avalon-MM read strobe
//   avm_waitrequest  in   slave stall
//   avm_readdata     in   read data
//   busy             out  check in progress
//   done             out  level, check finished (pass, fail or timeout)
//   id_ok            out  captured ID matched EXPECTED_ID (valid with done)
//   ts_ok            out  captured timestamp matched EXPECTED_TS (valid with done)
//   timeout          out  a read stalled for TIMEOUT_CYCLES cycles
//   captured_id      out  last ID word read
//   captured_ts      out  last timestamp word read
//   dbg_state        out  current FSM state, for debug and checkers
//
// Handshake: avm_read acts as "valid" and !avm_waitrequest as "ready". A read
// completes on the rising edge where avm_read=1 and avm_waitrequest=0; that
// is the edge where avm_readdata is captured. While avm_waitrequest=1 the
// master holds avm_read and avm_address unchanged. The master never writes.
// ---------------------------------------------------------------------------
module niosii_system_sysid_checker #(
   parameter int unsigned          ADDR_W         = 32,
   parameter logic [ADDR_W-1:0]    BASE_ADDR      = '0,
   parameter logic [31:0]          EXPECTED_ID    = 32'h0000_0000,
   parameter logic [31:0]          EXPECTED_TS    = 32'h589E_4C67,
   parameter int unsigned          TIMEOUT_CYCLES = 255,
   parameter bit                   AUTO_START     = 1'b1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic [31:0]       avm_readdata,
   output logic              busy,
   output logic              done,
   output logic              id_ok,
   output logic              ts_ok,
   output logic              timeout,
   output logic [31:0]       captured_id,
   output logic [31:0]       captured_ts,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_ID = 3'd1,
      RD_TS = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Word-aligned addresses of the two sysid registers.
   localparam logic [ADDR_W-1:0] ID_ADDR = {BASE_ADDR[ADDR_W-1:2], 2'b00};
   localparam logic [ADDR_W-1:0] TS_ADDR = ID_ADDR + ADDR_W'(4);
   // Stall count value at which the next stalled cycle is the last allowed one.
   localparam logic [15:0]       STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t            state_q, state_d;
   logic              armed_q, armed_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              read_q, read_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              id_ok_q, id_ok_d;
   logic              ts_ok_q, ts_ok_d;
   logic              timeout_q, timeout_d;
   logic [31:0]       cap_id_q, cap_id_d;
   logic [31:0]       cap_ts_q, cap_ts_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         armed_q   <= AUTO_START;
         cnt_q     <= '0;
         read_q    <= 1'b0;
         addr_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         id_ok_q   <= 1'b0;
         ts_ok_q   <= 1'b0;
         timeout_q <= 1'b0;
         cap_id_q  <= '0;
         cap_ts_q  <= '0;
      end else begin
         state_q   <= state_d;
         armed_q   <= armed_d;
         cnt_q     <= cnt_d;
         read_q    <= read_d;
         addr_q    <= addr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         id_ok_q   <= id_ok_d;
         ts_ok_q   <= ts_ok_d;
         timeout_q <= timeout_d;
         cap_id_q  <= cap_id_d;
         cap_ts_q  <= cap_ts_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      armed_d   = armed_q;
      cnt_d     = cnt_q;
      read_d    = read_q;
      addr_d    = addr_q;
      busy_d    = busy_q;
      done_d    = done_q;
      id_ok_d   = id_ok_q;
      ts_ok_d   = ts_ok_q;
      timeout_d = timeout_q;
      cap_id_d  = cap_id_q;
      cap_ts_d  = cap_ts_q;

      case (state_q)
         IDLE, DONE: begin
            // The armed flag only matters in IDLE: it fires the one-shot
            // check after reset. A start in DONE is a restart; it clears the
            // previous verdict but leaves the captured words in place.
            if (start || (state_q == IDLE && armed_q)) begin
               state_d   = RD_ID;
               armed_d   = 1'b0;
               cnt_d     = '0;
               read_d    = 1'b1;
               addr_d    = ID_ADDR;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               id_ok_d   = 1'b0;
               ts_ok_d   = 1'b0;
               timeout_d = 1'b0;
            end
         end

         RD_ID, RD_TS: begin
            if (!avm_waitrequest) begin
               // Acceptance wins over the stall limit.
               cnt_d = '0;
               if (state_q == RD_ID) begin
                  cap_id_d = avm_readdata;
                  addr_d   = TS_ADDR;
                  state_d  = RD_TS;
               end else begin
                  cap_ts_d = avm_readdata;
                  read_d   = 1'b0;
                  state_d  = CHECK;
               end
            end else if (cnt_q == STALL_LAST) begin
               // This stalled cycle brings the count to TIMEOUT_CYCLES.
               cnt_d     = cnt_q + 16'd1;
               read_d    = 1'b0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               timeout_d = 1'b1;
               id_ok_d   = 1'b0;
               ts_ok_d   = 1'b0;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         CHECK: begin
            id_ok_d = (cap_id_q == EXPECTED_ID);
            ts_ok_d = (cap_ts_q == EXPECTED_TS);
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
         end

         default: begin
            state_d = IDLE;
            read_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign avm_address = addr_q;
   assign avm_read    = read_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign id_ok       = id_ok_q;
   assign ts_ok       = ts_ok_q;
   assign timeout     = timeout_q;
   assign captured_id = cap_id_q;
   assign captured_ts = cap_ts_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// ---------------------------------------------------------------------------
// tb_niosii_system_sysid_checker
//
// Bench for niosii_system_sysid_checker with TIMEOUT_CYCLES=4 and
// AUTO_START=1. A sysid slave model answers reads with programmable stall
// counts per register. A transaction-level model derives, from the stall
// counts and the launch edge, when each read ends, whether it times out and
// when done rises; the compare process checks every output each cycle.
// Directed scenarios add literal expectations for latency and the verdict.
// ---------------------------------------------------------------------------
module tb_niosii_system_sysid_checker;

   localparam int          T      = 4;
   localparam logic [31:0] EXP_ID = 32'h0000_0000;
   localparam logic [31:0] EXP_TS = 32'h589E_4C67;

   // clock / reset
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   always #5 clock = ~clock;

   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_waitrequest = 1'b0;
   logic [31:0] avm_readdata = 32'hDEAD_BEEF;
   logic        busy, done, id_ok, ts_ok, timeout;
   logic [31:0] captured_id, captured_ts;
   logic [2:0]  dbg_state;

   niosii_system_sysid_checker #(
      .ADDR_W(32), .BASE_ADDR(32'h0), .EXPECTED_ID(EXP_ID),
      .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(T), .AUTO_START(1'b1)
   ) dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .avm_address(avm_address), .avm_read(avm_read),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok),
      .timeout(timeout), .captured_id(captured_id),
      .captured_ts(captured_ts), .dbg_state(dbg_state)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   always @(posedge clock) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   // slave model configuration
   int          w1 = 0, w2 = 0;
   logic [31:0] id_val = 32'h0, ts_val = EXP_TS;

   // slave: stall count per read, counted from what the DUT saw at each edge
   int   stall = 0;
   logic smp_stalled = 1'b0;
   always @(negedge clock) smp_stalled = avm_read && avm_waitrequest;
   always @(posedge clock) begin
      if (smp_stalled) stall++;
      else stall = 0;
      #1;
      if (avm_read) begin
         avm_waitrequest = (stall < ((avm_address == 32'h4) ? w2 : w1));
         avm_readdata    = (avm_address == 32'h4) ? ts_val : id_val;
      end else begin
         avm_waitrequest = 1'b0;
         avm_readdata    = 32'hDEAD_BEEF;
      end
   end

   // transaction-level model
   logic        pend = 1'b0, act = 1'b0;
   int          pend_k = 0, last_k = 0, k = 0;
   int          e1, e2, fin;
   logic        to1, to2;
   logic [31:0] s_id, s_ts;
   logic        m_done = 0, m_id_ok = 0, m_ts_ok = 0, m_to = 0;
   logic [31:0] m_cap_id = 0, m_cap_ts = 0;

   function automatic logic model_busy();
      return pend || (act && (cyc - k) < fin);
   endfunction

   task automatic model_clear();
      pend = 0; act = 0;
      m_done = 0; m_id_ok = 0; m_ts_ok = 0; m_to = 0;
      m_cap_id = 0; m_cap_ts = 0;
   endtask

   // compare process: one check of every output per cycle
   int          d;
   logic        e_read, e_busy;
   logic [31:0] e_addr;
   always @(negedge clock) begin
      if (pend && cyc >= pend_k) begin
         pend = 0; act = 1; k = pend_k;
         s_id = id_val; s_ts = ts_val;
         to1 = (w1 >= T);
         e1  = to1 ? T : w1 + 1;
         to2 = !to1 && (w2 >= T);
         e2  = e1 + (to2 ? T : w2 + 1);
         fin = to1 ? e1 : (to2 ? e2 : e2 + 1);
         m_done = 0; m_id_ok = 0; m_ts_ok = 0; m_to = 0;
      end
      e_read = 0; e_busy = 0; e_addr = 0;
      if (act) begin
         d      = cyc - k;
         e_busy = (d < fin);
         e_read = (d < e1) || (!to1 && d < e2);
         e_addr = (d < e1) ? 32'h0 : 32'h4;
         if (!to1 && d == e1) m_cap_id = s_id;
         if (!to1 && !to2 && d == e2) m_cap_ts = s_ts;
         if (d == fin) begin
            m_done  = 1;
            m_to    = to1 || to2;
            m_id_ok = !m_to && (s_id == EXP_ID);
            m_ts_ok = !m_to && (s_ts == EXP_TS);
            act     = 0;
         end
      end
      chk("avm_read", avm_read, e_read);
      if (e_read) chk("avm_address", avm_address, e_addr);
      chk("busy", busy, e_busy);
      chk("done", done, m_done);
      chk("id_ok", id_ok, m_id_ok);
      chk("ts_ok", ts_ok, m_ts_ok);
      chk("timeout", timeout, m_to);
      chk("captured_id", captured_id, m_cap_id);
      chk("captured_ts", captured_ts, m_cap_ts);
   end

   // driver tasks
   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      if (!model_busy()) begin
         pend = 1; pend_k = cyc + 1; last_k = pend_k;
      end
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic release_reset();
      @(negedge clock);
      reset_n = 1'b1;
      pend = 1; pend_k = cyc + 1; last_k = pend_k;
   endtask

   task automatic wait_done(output int el);
      el = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         if (done) begin
            el = cyc - last_k;
            break;
         end
      end
   endtask

   int el;
   initial begin
      // reset values
      #13;
      chk("rst_read", avm_read, 0);
      chk("rst_address", avm_address, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_captured_ts", captured_ts, 0);
      repeat (2) @(negedge clock);

      // 1: auto-start after reset, zero-wait slave, matching words
      release_reset();
      wait_done(el);
      chk("t1_latency", el, 3);
      chk("t1_id_ok", id_ok, 1);
      chk("t1_ts_ok", ts_ok, 1);
      chk("t1_timeout", timeout, 0);

      // 2: timestamp off by one
      ts_val = 32'h589E_4C66;
      pulse_start();
      wait_done(el);
      chk("t2_latency", el, 3);
      chk("t2_id_ok", id_ok, 1);
      chk("t2_ts_ok", ts_ok, 0);
      chk("t2_captured_ts", captured_ts, 32'h589E_4C66);

      // 2b: ID mismatch, timestamp correct
      ts_val = EXP_TS; id_val = 32'h0000_0001;
      pulse_start();
      wait_done(el);
      chk("t2b_id_ok", id_ok, 0);
      chk("t2b_ts_ok", ts_ok, 1);
      chk("t2b_captured_id", captured_id, 32'h1);

      // 3: three stall cycles per read, one below the limit
      id_val = 32'h0; w1 = 3; w2 = 3;
      pulse_start();
      wait_done(el);
      chk("t3_latency", el, 9);
      chk("t3_id_ok", id_ok, 1);
      chk("t3_timeout", timeout, 0);

      // 4: stuck on the ID read
      w1 = 100; w2 = 0;
      pulse_start();
      wait_done(el);
      chk("t4_latency", el, 4);
      chk("t4_timeout", timeout, 1);
      chk("t4_id_ok", id_ok, 0);

      // 4b: exactly TIMEOUT_CYCLES stalls on the timestamp read
      w1 = 0; w2 = T;
      pulse_start();
      wait_done(el);
      chk("t4b_latency", el, 5);
      chk("t4b_timeout", timeout, 1);
      chk("t4b_ts_ok", ts_ok, 0);

      // 5: start while busy is ignored, start in DONE restarts
      w1 = 3; w2 = 3;
      pulse_start();
      pulse_start();
      wait_done(el);
      chk("t5_latency", el, 9);
      pulse_start();
      chk("t5_restart_done", done, 0);
      chk("t5_restart_timeout", timeout, 0);
      wait_done(el);
      chk("t5_rerun_latency", el, 9);
      chk("t5_rerun_ts_ok", ts_ok, 1);

      // 6: reset during the timestamp read, then auto-check again
      w1 = 0; w2 = 5;
      pulse_start();
      @(posedge clock);
      @(posedge clock);
      #3;
      reset_n = 1'b0;
      model_clear();
      #1;
      chk("t6_read_async", avm_read, 0);
      chk("t6_busy_async", busy, 0);
      chk("t6_captured_id_async", captured_id, 0);
      w2 = 0;
      repeat (2) @(negedge clock);
      release_reset();
      wait_done(el);
      chk("t6_latency", el, 3);
      chk("t6_id_ok", id_ok, 1);
      chk("t6_ts_ok", ts_ok, 1);

      repeat (2) @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
